// File: rtl/estu_pkg.sv
// Shared definitions for the timestep scheduler: FSM encoding, default parameters and the
// op_id -> control-unit PC mapping.
package estu_pkg;

    localparam int unsigned PcStrideDef   = 6;
    localparam int unsigned WdogCyclesDef = 4096;
    localparam int unsigned AccW          = 21;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StTsEnd,
        StFinish
    } state_e;

    function automatic logic [7:0] pc_of(input logic [4:0] op_id, input int unsigned stride);
        return 8'({27'd0, op_id} * stride);
    endfunction

endpackage

// File: rtl/estu_wdog.sv
// Op-completion watchdog: counts enabled cycles and pulses o_expire on the Cycles-th
// consecutive enabled cycle without a clear.
module estu_wdog #(
    parameter int unsigned Cycles = 4096
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int unsigned CntW = (Cycles > 1) ? $clog2(Cycles) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(Cycles - 1);

    logic [CntW-1:0] cnt_q;

    assign o_expire = i_enable && !i_clear && (cnt_q == CntMax);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else if (i_clear || o_expire) begin
            cnt_q <= '0;
        end else if (i_enable) begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

endmodule

// File: rtl/estu_ts_scheduler.sv
// Timestep scheduler: steps op_ids through the control unit for each timestep, flips the
// ping-pong memory select between timesteps and accumulates last-layer results per run.
module estu_ts_scheduler
    import estu_pkg::*;
#(
    parameter int unsigned PC_STRIDE   = PcStrideDef,
    parameter int unsigned WDOG_CYCLES = WdogCyclesDef
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [7:0]      i_num_ts,
    input  logic [4:0]      i_num_ops,
    input  logic            i_abort,
    output logic            o_op_valid,
    output logic [4:0]      o_op_id,
    output logic [7:0]      o_pc,
    input  logic            i_op_done,
    output logic            o_pp_sel,
    output logic [7:0]      o_timestep,
    input  logic            i_last_valid,
    input  logic [12:0]     i_last_data,
    output logic [AccW-1:0] o_acc,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_err
);

    state_e            state_q;
    logic [7:0]        num_ts_q;
    logic [4:0]        num_ops_q;
    logic              op_valid_q;
    logic [4:0]        op_id_q;
    logic              pp_sel_q;
    logic [7:0]        timestep_q;
    logic [AccW-1:0]   acc_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic              last_valid_q;

    logic wdog_clear;
    logic wdog_enable;
    logic wdog_expire;
    logic lv_rise;
    logic abort_run;

    assign wdog_enable = (state_q == StWait);
    assign wdog_clear  = (state_q != StWait) || i_op_done;
    assign lv_rise     = i_last_valid && !last_valid_q;
    assign abort_run   = i_abort && (state_q == StIssue || state_q == StWait || state_q == StTsEnd);

    estu_wdog #(
        .Cycles (WDOG_CYCLES)
    ) u_wdog (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clear  (wdog_clear),
        .i_enable (wdog_enable),
        .o_expire (wdog_expire)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= StIdle;
            num_ts_q     <= '0;
            num_ops_q    <= '0;
            op_valid_q   <= 1'b0;
            op_id_q      <= '0;
            pp_sel_q     <= 1'b0;
            timestep_q   <= '0;
            acc_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            last_valid_q <= 1'b0;
        end else begin
            done_q       <= 1'b0;
            op_valid_q   <= 1'b0;
            last_valid_q <= i_last_valid;
            // Still busy on the edge into FINISH, so a coincident result is kept.
            if (busy_q && lv_rise) begin
                acc_q <= acc_q + AccW'(i_last_data);
            end
            if (abort_run) begin
                state_q <= StFinish;
                done_q  <= 1'b1;
                busy_q  <= 1'b1;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (i_start) begin
                            if (i_num_ts != 8'd0 && i_num_ops != 5'd0) begin
                                num_ts_q   <= i_num_ts;
                                num_ops_q  <= i_num_ops;
                                acc_q      <= '0;
                                err_q      <= 1'b0;
                                timestep_q <= '0;
                                op_id_q    <= '0;
                                pp_sel_q   <= 1'b0;
                                op_valid_q <= 1'b1;
                                busy_q     <= 1'b1;
                                state_q    <= StIssue;
                            end else begin
                                done_q <= 1'b1;
                            end
                        end
                    end
                    StIssue: begin
                        state_q <= StWait;
                    end
                    StWait: begin
                        if (i_op_done) begin
                            if (op_id_q == num_ops_q - 5'd1) begin
                                state_q <= StTsEnd;
                            end else begin
                                op_id_q    <= op_id_q + 5'd1;
                                op_valid_q <= 1'b1;
                                state_q    <= StIssue;
                            end
                        end else if (wdog_expire) begin
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= StFinish;
                        end
                    end
                    StTsEnd: begin
                        pp_sel_q <= ~pp_sel_q;
                        op_id_q  <= '0;
                        if (timestep_q == num_ts_q - 8'd1) begin
                            done_q  <= 1'b1;
                            state_q <= StFinish;
                        end else begin
                            timestep_q <= timestep_q + 8'd1;
                            op_valid_q <= 1'b1;
                            state_q    <= StIssue;
                        end
                    end
                    StFinish: begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                    default: begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign o_op_valid = op_valid_q;
    assign o_op_id    = op_id_q;
    assign o_pc       = pc_of(op_id_q, PC_STRIDE);
    assign o_pp_sel   = pp_sel_q;
    assign o_timestep = timestep_q;
    assign o_acc      = acc_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_err      = err_q;

endmodule

// File: doc/estu_ts_scheduler.md
ESTU_TS_SCHEDULER -- requirements
Module: estu_ts_scheduler

Interface
REQ-001 SHALL have parameter PC_STRIDE, default 6: control-unit PC increment per op_id.
REQ-002 SHALL have parameter WDOG_CYCLES, default 4096: maximum cycles to wait for i_op_done.
REQ-003 SHALL have port i_clk  input  1: single clock.
REQ-004 SHALL have port i_rst  input  1: reset, asynchronous, active-high.
REQ-005 SHALL have port i_start  input  1: one-cycle run request, sampled in IDLE only.
REQ-006 SHALL have port i_num_ts  input  8: timesteps per run, sampled on accepted start.
REQ-007 SHALL have port i_num_ops  input  5: op_ids per timestep, sampled on accepted start.
REQ-008 SHALL have port i_abort  input  1: terminate the current run.
REQ-009 SHALL have port o_op_valid  output  1: op issue request to the control unit.
REQ-010 SHALL have port o_op_id  output  5: current op_id.
REQ-011 SHALL have port o_pc  output  8: o_op_id*PC_STRIDE, truncated to 8 bits.
REQ-012 SHALL have port i_op_done  input  1: op-completion pulse from the control unit.
REQ-013 SHALL have port o_pp_sel  output  1: ping-pong select; 0 = read sm1/intmem1, write sm2/intmem2; 1 = reverse.
REQ-014 SHALL have port o_timestep  output  8: current timestep index.
REQ-015 SHALL have ports i_last_valid  input  1 and i_last_data  input  13: last-layer result.
REQ-016 SHALL have port o_acc  output  21: sum of last-layer results for the run.
REQ-017 SHALL have ports o_busy  output  1, o_done  output  1 (pulse), o_err  output  1 (sticky watchdog flag).

Function
REQ-018 SHALL implement states IDLE, ISSUE, WAIT, TS_END, FINISH.
REQ-019 IDLE: i_start=1 with i_num_ts!=0 and i_num_ops!=0 -> latch both counts, clear o_acc, o_err, o_timestep, o_op_id, o_pp_sel; go to ISSUE. A start with either count zero -> o_done pulse on the next cycle, stay IDLE.
REQ-020 ISSUE: assert o_op_valid for exactly one cycle; go to WAIT next cycle.
REQ-021 WAIT: count cycles. On i_op_done: if o_op_id==num_ops-1 go to TS_END, otherwise increment o_op_id and go to ISSUE. This gives 2 cycles minimum per op.
REQ-022 i_op_done outside WAIT SHALL be ignored.
REQ-023 Watchdog: WDOG_CYCLES consecutive cycles in WAIT without i_op_done -> set o_err and go to FINISH.
REQ-024 TS_END, one cycle: toggle o_pp_sel, clear o_op_id. If o_timestep==num_ts-1 go to FINISH, otherwise increment o_timestep and go to ISSUE.
REQ-025 FINISH, one cycle: o_done=1; then IDLE. o_timestep, o_pp_sel and o_acc hold until the next accepted start.
REQ-026 Accumulation: on each rising edge of i_last_valid (edge detected internally, registered) while o_busy=1, o_acc += zero-extended i_last_data. Level-held valid counts once. No overflow is possible: 255*8191 < 2^21.
REQ-027 A rising edge of i_last_valid coincident with the transition into FINISH SHALL still accumulate.
REQ-028 i_abort in any non-IDLE state -> FINISH next cycle. o_err is not set, o_op_valid=0. i_abort in IDLE is ignored.
REQ-029 If i_abort and i_op_done are simultaneous, abort wins.
REQ-030 o_busy=1 in every state except IDLE.
REQ-031 All outputs SHALL be registered except o_pc, which is derived combinationally from the o_op_id register.

Reset
REQ-032 i_rst SHALL force IDLE immediately, including mid-run. All outputs SHALL go to 0, the edge-detect register to 0, and the watchdog counter to 0.
REQ-033 The first accepted start after reset SHALL behave identically to any other start.

Structure
REQ-034 The state encoding, PC_STRIDE default, WDOG_CYCLES default and the 21-bit accumulator width SHALL live in the shared package estu_pkg.
REQ-035 The watchdog SHALL be the sub-module estu_wdog: inputs clear and enable, output expire pulse.

Verification
REQ-036 num_ts=2, num_ops=3, i_op_done 5 cycles after each o_op_valid -> 6 issue pulses with op_id 0,1,2,0,1,2, o_pc 0,6,12,0,6,12, o_pp_sel 0 then 1; o_done once; final o_pp_sel=0.
REQ-037 i_last_valid pulses carrying 100, 8191 and 1 -> o_acc=8292. A valid held for 4 cycles adds once.
REQ-038 i_op_done never returns, WDOG_CYCLES=16 -> o_err=1 and o_done exactly 16 cycles after WAIT entry.
REQ-039 i_abort coincident with i_op_done on op 1 -> no further o_op_valid, o_done next cycle, o_err=0.
REQ-040 i_rst asserted mid-WAIT -> all outputs 0 asynchronously; a subsequent start runs normally.
REQ-041 i_start with i_num_ops=0 -> o_done pulse, no o_op_valid, o_acc unchanged.
